// File: rtl/flow_rec_pkg.sv
// flow_rec_pkg: flow record field offsets, reason codes and scanner state encoding
package flow_rec_pkg;
    localparam int PROTO_LSB    = 136;
    localparam int FIN_BIT      = 128;
    localparam int RST_BIT      = 130;
    localparam int FIRST_TS_LSB = 96;
    localparam int LAST_TS_LSB  = 64;
    localparam logic [7:0] TCP  = 8'd6;

    typedef enum logic [1:0] {
        RSN_FORCED   = 2'b00,
        RSN_ACTIVE   = 2'b01,
        RSN_INACTIVE = 2'b10,
        RSN_TCP      = 2'b11
    } reason_e;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EVAL, PUSH, CLEAR} state_e;
endpackage

// File: rtl/flow_expiry_check.sv
// flow_expiry_check: combinational expiry test and reason priority for one record
module flow_expiry_check
    import flow_rec_pkg::*;
#(
    parameter int TS_W          = 32,
    parameter int TCP_EXPORT_EN = 1
) (
    input  logic            valid,
    input  logic [7:0]      protocol,
    input  logic            fin,
    input  logic            tcp_rst,
    input  logic [TS_W-1:0] first_ts,
    input  logic [TS_W-1:0] last_ts,
    input  logic [TS_W-1:0] now,
    input  logic [TS_W-1:0] active_timeout,
    input  logic [TS_W-1:0] inactive_timeout,
    input  logic            forced,
    output logic            expired,
    output reason_e         reason
);
    logic [TS_W-1:0] age, idle;
    logic act, inact, tcp_end;

    // Ages are modular so a wrapped timestamp counter still yields the true distance
    always_comb begin
        age     = now - first_ts;
        idle    = now - last_ts;
        act     = age >= active_timeout;
        inact   = idle >= inactive_timeout;
        tcp_end = (TCP_EXPORT_EN != 0) && protocol == TCP && (fin || tcp_rst);
        expired = forced || (valid && (act || inact || tcp_end));
        reason  = forced ? RSN_FORCED : tcp_end ? RSN_TCP : act ? RSN_ACTIVE : RSN_INACTIVE;
    end
endmodule

// File: rtl/flow_expiry_scanner.sv
// flow_expiry_scanner: background sweep of the flow table exporting and clearing expired records
module flow_expiry_scanner
    import flow_rec_pkg::*;
#(
    parameter int ADDR_W        = 12,
    parameter int REC_W         = 241,
    parameter int TS_W          = 32,
    parameter int RD_LAT        = 1,
    parameter int TCP_EXPORT_EN = 1
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic [TS_W-1:0]   active_timeout,
    input  logic [TS_W-1:0]   inactive_timeout,
    input  logic [TS_W-1:0]   timestamp_counter,
    input  logic              scan_en,
    input  logic              export_req,
    input  logic [ADDR_W-1:0] export_addr,
    output logic              export_ack,
    output logic              export_pending,
    output logic [ADDR_W-1:0] addrb,
    output logic              enb,
    output logic              web,
    output logic [REC_W-1:0]  dib,
    input  logic [REC_W-1:0]  dob,
    input  logic              fifo_full_exp,
    output logic              fifo_w_exp_en,
    output logic [REC_W:0]    fifo_in_exp,
    output logic [31:0]       exported_cnt,
    output logic              sweep_done
);
    state_e            state, state_nx;
    logic [ADDR_W-1:0] scan_ptr, pend_addr;
    logic [REC_W-1:0]  reg_rec;
    logic [2:0]        wait_cnt;
    logic              forced, expired, take_forced, take_scan, last_wait, ptr_step;
    reason_e           reason, reason_q;

    flow_expiry_check #(.TS_W(TS_W), .TCP_EXPORT_EN(TCP_EXPORT_EN)) u_check (
        .valid            (reg_rec[REC_W-1]),
        .protocol         (reg_rec[PROTO_LSB +: 8]),
        .fin              (reg_rec[FIN_BIT]),
        .tcp_rst          (reg_rec[RST_BIT]),
        .first_ts         (reg_rec[FIRST_TS_LSB +: TS_W]),
        .last_ts          (reg_rec[LAST_TS_LSB +: TS_W]),
        .now              (timestamp_counter),
        .active_timeout   (active_timeout),
        .inactive_timeout (inactive_timeout),
        .forced           (forced),
        .expired          (expired),
        .reason           (reason)
    );

    assign enb           = state == ISSUE || state == CLEAR;
    assign web           = state == CLEAR;
    assign dib           = '0;
    assign fifo_w_exp_en = state == PUSH && !fifo_full_exp;
    assign fifo_in_exp   = {reason_q, reg_rec[REC_W-2:0]};

    // Next-state decode; a pending forced export always wins over the sweep
    always_comb begin
        take_forced = state == IDLE && export_pending;
        take_scan   = state == IDLE && !export_pending && scan_en;
        last_wait   = wait_cnt == 3'(RD_LAT - 1);
        ptr_step    = (state == EVAL && !expired) || (state == CLEAR && !forced);
        state_nx    = state;
        case (state)
            IDLE:    state_nx = (take_forced || take_scan) ? ISSUE : IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = last_wait ? EVAL : WAIT;
            EVAL:    state_nx = !expired ? IDLE : reg_rec[REC_W-1] ? PUSH : CLEAR;
            PUSH:    state_nx = fifo_full_exp ? PUSH : CLEAR;
            CLEAR:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= IDLE;
        else          state <= state_nx;
    end

    // Address selection, read capture, sweep pointer and export bookkeeping
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            addrb        <= '0;
            forced       <= 1'b0;
            wait_cnt     <= '0;
            reg_rec      <= '0;
            reason_q     <= RSN_FORCED;
            scan_ptr     <= '0;
            sweep_done   <= 1'b0;
            export_ack   <= 1'b0;
            exported_cnt <= '0;
        end else begin
            if (take_forced) begin
                addrb  <= pend_addr;
                forced <= 1'b1;
            end else if (take_scan) begin
                addrb  <= scan_ptr;
                forced <= 1'b0;
            end
            wait_cnt <= state == WAIT ? wait_cnt + 3'd1 : 3'd0;
            if (state == WAIT && last_wait) reg_rec <= dob;
            if (state == EVAL) reason_q <= reason;
            if (ptr_step) scan_ptr <= scan_ptr + 1'b1;
            sweep_done <= ptr_step && &scan_ptr;
            export_ack <= state == CLEAR && forced;
            if (fifo_w_exp_en) exported_cnt <= exported_cnt + 32'd1;
        end
    end

    // Forced-request latch; a new request may be taken in the cycle the old one is served
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            export_pending <= 1'b0;
            pend_addr      <= '0;
        end else begin
            export_pending <= take_forced ? export_req : export_pending || export_req;
            if (export_req && (!export_pending || take_forced)) pend_addr <= export_addr;
        end
    end
endmodule
